fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one `fifo` instance between `N_REQ` independent producers. Each producer offers words over a valid/ready handshake. The arbiter grants the FIFO write port to one producer at a time, for bursts of up to `MAX_BURST` words, and stalls on `fifo_full_i`. It sits directly in front of the FIFO `data_i`/`wrreq_i` pins, with no buffering of its own.

---
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N_REQ producers, the round-robin arbiter and the
// shared FIFO write port. The arbiter uses the slave view; the producer/FIFO
// side (or a bench) uses the master view.
interface fifo_wr_arbiter_if #(
   parameter int DWIDTH = 8,
   parameter int N_REQ  = 4
);
   logic [N_REQ*DWIDTH-1:0] req_data_i;
   logic [N_REQ-1:0]        req_valid_i;
   logic [N_REQ-1:0]        req_ready_o;
   logic [N_REQ-1:0]        grant_o;
   logic [DWIDTH-1:0]       fifo_data_o;
   logic                    fifo_wrreq_o;
   logic                    fifo_full_i;

   modport master (
      output req_data_i, req_valid_i, fifo_full_i,
      input  req_ready_o, grant_o, fifo_data_o, fifo_wrreq_o
   );

   modport slave (
      input  req_data_i, req_valid_i, fifo_full_i,
      output req_ready_o, grant_o, fifo_data_o, fifo_wrreq_o
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between N_REQ
// producers. The owner keeps the port for up to MAX_BURST words, loses it as
// soon as its valid drops, and simply stalls while the FIFO reports full.
// Handover to the next owner happens on the releasing edge, so there is no
// bubble cycle between bursts.
module fifo_wr_arbiter #(
   parameter int DWIDTH    = 8,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                clk_i,
   input  logic                arstn_i,
   fifo_wr_arbiter_if.slave    bus
);
   localparam int OW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Reset owner is the last producer so producer 0 is searched first.
   localparam logic [OW-1:0] OWNER_RST = OW'(N_REQ - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

   function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
      logic [N_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   logic [0:0]        state_r, state_nxt_s;
   logic [OW-1:0]     owner_r, owner_nxt_s;
   logic [BW-1:0]     beat_cnt_r, beat_cnt_nxt_s;
   logic [N_REQ-1:0]  grant_r, grant_nxt_s;

   logic              owner_valid_s;
   logic              transfer_s;
   logic              release_s;
   logic              pick_valid_s;
   logic [OW-1:0]     pick_s;
   logic [N_REQ-1:0]  ready_s;
   logic [DWIDTH-1:0] data_s;

   assign owner_valid_s = bus.req_valid_i[owner_r];
   assign transfer_s    = (state_r == ST_GRANT) && owner_valid_s && !bus.fifo_full_i;
   // A full FIFO never releases: only a valid drop or a completed burst does.
   assign release_s     = !owner_valid_s || (transfer_s && (beat_cnt_r == BEAT_LAST));

   // Round-robin search starting after the current owner, owner itself last.
   always_comb begin
      int              cand;
      logic [OW-1:0]   cand_idx;
      pick_s       = owner_r;
      pick_valid_s = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand     = int'(owner_r) + k;
         cand     = (cand >= N_REQ) ? (cand - N_REQ) : cand;
         cand_idx = OW'(cand);
         if (!pick_valid_s && bus.req_valid_i[cand_idx]) begin
            pick_valid_s = 1'b1;
            pick_s       = cand_idx;
         end else begin
            pick_valid_s = pick_valid_s;
         end
      end
   end

   // Next-state logic for the IDLE/GRANT controller and the registered grant.
   always_comb begin
      state_nxt_s    = state_r;
      owner_nxt_s    = owner_r;
      beat_cnt_nxt_s = beat_cnt_r;
      grant_nxt_s    = grant_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s    = ST_GRANT;
               owner_nxt_s    = pick_s;
               beat_cnt_nxt_s = '0;
               grant_nxt_s    = onehot(pick_s);
            end else begin
               grant_nxt_s    = '0;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               if (pick_valid_s) begin
                  owner_nxt_s    = pick_s;
                  beat_cnt_nxt_s = '0;
                  grant_nxt_s    = onehot(pick_s);
               end else begin
                  state_nxt_s    = ST_IDLE;
                  beat_cnt_nxt_s = '0;
                  grant_nxt_s    = '0;
               end
            end else if (transfer_s) begin
               beat_cnt_nxt_s = beat_cnt_r + BW'(1);
            end else begin
               beat_cnt_nxt_s = beat_cnt_r;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            beat_cnt_nxt_s = '0;
            grant_nxt_s    = '0;
         end
      endcase
   end

   // Controller state, owner, burst counter and grant registers.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_r    <= ST_IDLE;
         owner_r    <= OWNER_RST;
         beat_cnt_r <= '0;
         grant_r    <= '0;
      end else begin
         state_r    <= state_nxt_s;
         owner_r    <= owner_nxt_s;
         beat_cnt_r <= beat_cnt_nxt_s;
         grant_r    <= grant_nxt_s;
      end
   end

   // Accept strobe back to the owning producer only on an actual write.
   always_comb begin
      ready_s = '0;
      if (transfer_s) begin
         ready_s = onehot(owner_r);
      end else begin
         ready_s = '0;
      end
   end

   // Route the owner's word to the FIFO; drive zero while idle.
   always_comb begin
      data_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if ((state_r == ST_GRANT) && (owner_r == OW'(i))) begin
            data_s = bus.req_data_i[i*DWIDTH +: DWIDTH];
         end else begin
            data_s = data_s;
         end
      end
   end

   assign bus.grant_o      = grant_r;
   assign bus.req_ready_o  = ready_s;
   assign bus.fifo_wrreq_o = transfer_s;
   assign bus.fifo_data_o  = data_s;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: four producer models (word = {id, seq})
// and a 16-deep FIFO model with a registered full flag.
module tb_fifo_wr_arbiter;
   logic clk_i = 1'b0;
   logic arstn_i;

   fifo_wr_arbiter_if #(.DWIDTH(8), .N_REQ(4)) bus ();

   fifo_wr_arbiter #(.DWIDTH(8), .N_REQ(4), .MAX_BURST(4)) dut (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   int ntests = 0;
   int nfail  = 0;
   int nwr;

   // Producer models: word = {producer id, sequence number}, limited count
   logic [7:0]  pcnt [4];
   logic [7:0]  plim [4];
   logic [3:0]  pen;
   logic        pclr;
   logic [3:0]  pvalid;
   logic [31:0] pdata;

   always @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (pclr) pcnt[i] <= 8'd0;
         else if (bus.req_ready_o[i]) pcnt[i] <= pcnt[i] + 8'd1;
      end
   end

   always_comb begin
      pvalid = 4'd0;
      pdata  = 32'd0;
      for (int i = 0; i < 4; i++) begin
         pvalid[i]       = pen[i] && (pcnt[i] < plim[i]);
         pdata[i*8 +: 8] = {4'(i), pcnt[i][3:0]};
      end
   end

   assign bus.req_valid_i = pvalid;
   assign bus.req_data_i  = pdata;

   // FIFO model, 16 deep
   logic [7:0] fifo_q [$];
   logic [4:0] fcnt = 5'd0;
   logic       frd;
   logic       fclr;

   always @(posedge clk_i) begin
      logic wr_ok, rd_ok;
      wr_ok = bus.fifo_wrreq_o && (fcnt != 5'd16);
      rd_ok = frd && (fcnt != 5'd0);
      if (fclr) begin
         fifo_q.delete();
         fcnt <= 5'd0;
      end else begin
         if (wr_ok) fifo_q.push_back(bus.fifo_data_o);
         if (rd_ok) void'(fifo_q.pop_front());
         fcnt <= fcnt + {4'd0, wr_ok} - {4'd0, rd_ok};
      end
   end

   assign bus.fifo_full_i = (fcnt == 5'd16);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic clean();
      pen     = 4'h0;
      frd     = 1'b0;
      arstn_i = 1'b0;
      fclr    = 1'b1;
      pclr    = 1'b1;
      for (int i = 0; i < 4; i++) plim[i] = 8'hFF;
      tick();
      fclr    = 1'b0;
      pclr    = 1'b0;
      arstn_i = 1'b1;
   endtask

   initial begin
      arstn_i = 1'b0;
      pen  = 4'h0;
      frd  = 1'b0;
      fclr = 1'b1;
      pclr = 1'b1;
      for (int i = 0; i < 4; i++) plim[i] = 8'hFF;
      tick();
      tick();

      // Reset held with every producer valid
      fclr = 1'b0;
      pclr = 1'b0;
      pen  = 4'hF;
      tick(); #1;
      chk("rst_grant", bus.grant_o, 32'h0);
      chk("rst_wrreq", bus.fifo_wrreq_o, 32'h0);
      chk("rst_ready", bus.req_ready_o, 32'h0);
      chk("rst_data",  bus.fifo_data_o, 32'h0);
      arstn_i = 1'b1; #1;
      chk("rel_grant_now", bus.grant_o, 32'h0);
      tick(); #1;
      chk("rel_grant_next", bus.grant_o, 32'h1);
      chk("rel_data", bus.fifo_data_o, 32'h00);

      // Sole producer 2, ten words, bursts 4+4+2 without bubbles
      clean();
      pen = 4'b0100; plim[2] = 8'd10;
      nwr = 0;
      repeat (10) begin
         tick(); #1;
         if (bus.fifo_wrreq_o === 1'b1 && bus.grant_o === 4'b0100) nwr++;
      end
      chk("sole_writes", nwr, 32'd10);
      tick(); #1;
      chk("sole_usedw", fcnt, 32'd10);
      chk("sole_first", fifo_q[0], 32'h20);
      chk("sole_last",  fifo_q[9], 32'h29);
      chk("sole_stop",  bus.fifo_wrreq_o, 32'h0);
      tick(); #1;
      chk("sole_idle",  bus.grant_o, 32'h0);

      // All four contend until the FIFO fills
      clean();
      pen = 4'hF;
      nwr = 0;
      repeat (17) begin
         tick(); #1;
         if (bus.fifo_wrreq_o === 1'b1) nwr++;
      end
      chk("rr_writes", nwr, 32'd16);
      chk("rr_usedw",  fcnt, 32'd16);
      chk("rr_full_grant", bus.grant_o, 32'h1);
      chk("rr_full_wrreq", bus.fifo_wrreq_o, 32'h0);
      for (int k = 0; k < 16; k++)
         chk($sformatf("rr_order%0d", k), fifo_q[k], 32'((k / 4) * 16 + (k % 4)));

      // FIFO fills while producer 1 is two beats into its burst
      clean();
      pen = 4'b0001; plim[0] = 8'd14;
      repeat (17) tick();
      #1;
      chk("full_prefill", fcnt, 32'd14);
      chk("full_pre_idle", bus.grant_o, 32'h0);
      pen = 4'b0010;
      repeat (3) tick();
      #1;
      chk("full_usedw", fcnt, 32'd16);
      chk("full_wrreq", bus.fifo_wrreq_o, 32'h0);
      chk("full_grant", bus.grant_o, 32'h2);
      repeat (2) tick();
      #1;
      chk("full_hold_grant", bus.grant_o, 32'h2);
      chk("full_hold_ready", bus.req_ready_o, 32'h0);
      pen = 4'b0110;
      frd = 1'b1;
      tick(); #1;
      chk("full_resume_wr",    bus.fifo_wrreq_o, 32'h1);
      chk("full_resume_data",  bus.fifo_data_o, 32'h12);
      chk("full_resume_ready", bus.req_ready_o, 32'h2);
      tick(); #1;
      chk("full_last_data",  bus.fifo_data_o, 32'h13);
      chk("full_last_grant", bus.grant_o, 32'h2);
      tick(); #1;
      frd = 1'b0;
      chk("full_moved_grant", bus.grant_o, 32'h4);
      chk("full_moved_data",  bus.fifo_data_o, 32'h20);
      chk("full_tail", fifo_q[fifo_q.size() - 1], 32'h13);

      // Producer 1 stops after two words; producer 2 takes over
      clean();
      pen = 4'b1110; plim[1] = 8'd2;
      tick(); #1;
      chk("drop_grant1", bus.grant_o, 32'h2);
      chk("drop_data0",  bus.fifo_data_o, 32'h10);
      tick(); #1;
      chk("drop_data1",  bus.fifo_data_o, 32'h11);
      tick(); #1;
      chk("drop_nowr",   bus.fifo_wrreq_o, 32'h0);
      chk("drop_hold",   bus.grant_o, 32'h2);
      tick(); #1;
      chk("drop_grant2", bus.grant_o, 32'h4);
      chk("drop_wr2",    bus.fifo_wrreq_o, 32'h1);
      chk("drop_data2",  bus.fifo_data_o, 32'h20);

      // Asynchronous reset in the middle of a producer 3 burst
      clean();
      pen = 4'b1000;
      repeat (3) tick();
      #1;
      chk("arst_pre_grant", bus.grant_o, 32'h8);
      chk("arst_pre_data",  bus.fifo_data_o, 32'h32);
      pen     = 4'b1001;
      arstn_i = 1'b0;
      #1;
      chk("arst_grant", bus.grant_o, 32'h0);
      chk("arst_wrreq", bus.fifo_wrreq_o, 32'h0);
      chk("arst_ready", bus.req_ready_o, 32'h0);
      chk("arst_data",  bus.fifo_data_o, 32'h0);
      arstn_i = 1'b1;
      tick(); #1;
      chk("arst_after_grant", bus.grant_o, 32'h1);
      chk("arst_after_data",  bus.fifo_data_o, 32'h00);
      chk("arst_kept_words",  fcnt, 32'd2);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
